collision_scorer: RTL

//   Pixel-level collision detector and score keeper between the VGA scan and the game logic.

---
 rtl/collision_scorer.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/collision_scorer.sv
// Per-frame pixel collision detector with BCD score and lives; hit pulses appear the cycle after the vs falling edge.
// Score add takes four further cycles (one BCD digit each); no backpressure, every frame edge is honoured or queued.
module collision_scorer #(
   parameter logic [9:0]  GRID_X0    = 10'd64,
   parameter logic [9:0]  GRID_Y0    = 10'd48,
   parameter int          CELL_SHIFT = 5,
   parameter int          COLS       = 11,
   parameter int          ROWS       = 5,
   parameter logic [15:0] POINTS_BCD = 16'h0010,
   parameter logic [1:0]  LIVES      = 2'd3
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   input  logic        vs,
   input  logic        is_playing,
   input  logic        start,
   input  logic        bullet_on,
   input  logic        enemy_on,
   input  logic        ebullet_on,
   input  logic        player_on,
   output logic        hit,
   output logic [3:0]  hit_col,
   output logic [2:0]  hit_row,
   output logic        player_hit,
   output logic [15:0] score_bcd,
   output logic [1:0]  lives,
   output logic        finished
);

   // ADDk encodings share bit 2 so the low bits index the score digit directly.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SCAN   = 3'd1,
      REPORT = 3'd2,
      OVER   = 3'd3,
      ADD0   = 3'd4,
      ADD1   = 3'd5,
      ADD2   = 3'd6,
      ADD3   = 3'd7
   } state_t;

   state_t      state_q, state_d;
   logic        vs_d_q;
   logic        e_flag_q, e_flag_d, p_flag_q, p_flag_d, pend_q, pend_d, carry_q, carry_d;
   logic [3:0]  col_q, col_d, hit_col_q, hit_col_d;
   logic [2:0]  row_q, row_d, hit_row_q, hit_row_d;
   logic        hit_q, hit_d, player_hit_q, player_hit_d, finished_q, finished_d;
   logic [15:0] score_q, score_d;
   logic [1:0]  lives_q, lives_d;

   logic        frame_edge, e_hit, p_hit, do_report;
   logic [9:0]  dx, dy, cell_x, cell_y;
   logic [1:0]  dig_idx;
   logic [3:0]  s_dig, p_dig, dig_res;
   logic [4:0]  dig_sum;
   logic        dig_carry;

   always_comb begin
      frame_edge = vs_d_q & ~vs;
      dx         = DrawX - GRID_X0;
      dy         = DrawY - GRID_Y0;
      cell_x     = dx >> CELL_SHIFT;
      cell_y     = dy >> CELL_SHIFT;
      e_hit      = bullet_on & enemy_on & (DrawX >= GRID_X0) & (DrawY >= GRID_Y0)
                   & (cell_x < 10'(COLS)) & (cell_y < 10'(ROWS));
      p_hit      = ebullet_on & player_on;

      dig_idx    = state_q[1:0];
      s_dig      = score_q[{dig_idx, 2'b00} +: 4];
      p_dig      = POINTS_BCD[{dig_idx, 2'b00} +: 4];
      dig_sum    = {1'b0, s_dig} + {1'b0, p_dig} + {4'b0, carry_q};
      dig_carry  = (dig_sum > 5'd9);
      dig_res    = dig_carry ? 4'(dig_sum - 5'd10) : dig_sum[3:0];
   end

   always_comb begin
      state_d      = state_q;
      e_flag_d     = e_flag_q;
      p_flag_d     = p_flag_q;
      pend_d       = pend_q;
      carry_d      = carry_q;
      col_d        = col_q;
      row_d        = row_q;
      hit_col_d    = hit_col_q;
      hit_row_d    = hit_row_q;
      hit_d        = 1'b0;
      player_hit_d = 1'b0;
      finished_d   = finished_q;
      score_d      = score_q;
      lives_d      = lives_q;
      do_report    = 1'b0;

      if (start) begin
         score_d    = 16'h0000;
         lives_d    = LIVES;
         finished_d = 1'b0;
         e_flag_d   = 1'b0;
         p_flag_d   = 1'b0;
         pend_d     = 1'b0;
         carry_d    = 1'b0;
         state_d    = is_playing ? SCAN : IDLE;
      end else if (!is_playing && state_q != OVER) begin
         state_d  = IDLE;
         e_flag_d = 1'b0;
         p_flag_d = 1'b0;
         pend_d   = 1'b0;
      end else begin
         if (state_q != IDLE && state_q != OVER) begin
            if (e_hit && !e_flag_q) begin
               e_flag_d = 1'b1;
               col_d    = cell_x[3:0];
               row_d    = cell_y[2:0];
            end
            if (p_hit) p_flag_d = 1'b1;
         end

         case (state_q)
            IDLE:   state_d = SCAN;
            SCAN:   do_report = frame_edge;
            REPORT: begin
               carry_d = 1'b0;
               if (frame_edge) pend_d = 1'b1;
               if (hit_q)                state_d = ADD0;
               else if (lives_q == 2'd0) state_d = OVER;
               else                      state_d = SCAN;
            end
            ADD0, ADD1, ADD2, ADD3: begin
               score_d[{dig_idx, 2'b00} +: 4] = dig_res;
               carry_d = dig_carry;
               if (frame_edge) pend_d = 1'b1;
               if (state_q == ADD3) begin
                  if (dig_carry) score_d = 16'h9999;
                  if (lives_q == 2'd0)          state_d = OVER;
                  else if (pend_q || frame_edge) do_report = 1'b1;
                  else                           state_d = SCAN;
               end else begin
                  state_d = state_t'(state_q + 3'd1);
               end
            end
            default: ;
         endcase

         // Reporting clears after the scan update so a same-cycle overlap cannot leak into the report.
         if (do_report) begin
            hit_d        = e_flag_q;
            player_hit_d = p_flag_q;
            if (e_flag_q) begin
               hit_col_d = col_q;
               hit_row_d = row_q;
            end
            if (p_flag_q && lives_q != 2'd0) lives_d = lives_q - 2'd1;
            e_flag_d = 1'b0;
            p_flag_d = 1'b0;
            pend_d   = 1'b0;
            state_d  = REPORT;
         end
         if (state_d == OVER) finished_d = 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q      <= IDLE;
         vs_d_q       <= 1'b0;
         e_flag_q     <= 1'b0;
         p_flag_q     <= 1'b0;
         pend_q       <= 1'b0;
         carry_q      <= 1'b0;
         col_q        <= 4'd0;
         row_q        <= 3'd0;
         hit_col_q    <= 4'd0;
         hit_row_q    <= 3'd0;
         hit_q        <= 1'b0;
         player_hit_q <= 1'b0;
         finished_q   <= 1'b0;
         score_q      <= 16'h0000;
         lives_q      <= LIVES;
      end else begin
         state_q      <= state_d;
         vs_d_q       <= vs;
         e_flag_q     <= e_flag_d;
         p_flag_q     <= p_flag_d;
         pend_q       <= pend_d;
         carry_q      <= carry_d;
         col_q        <= col_d;
         row_q        <= row_d;
         hit_col_q    <= hit_col_d;
         hit_row_q    <= hit_row_d;
         hit_q        <= hit_d;
         player_hit_q <= player_hit_d;
         finished_q   <= finished_d;
         score_q      <= score_d;
         lives_q      <= lives_d;
      end
   end

   assign hit        = hit_q;
   assign hit_col    = hit_col_q;
   assign hit_row    = hit_row_q;
   assign player_hit = player_hit_q;
   assign score_bcd  = score_q;
   assign lives      = lives_q;
   assign finished   = finished_q;

endmodule
